// File: rtl/alu_writeback_stage_if.sv
// ALU result / register-file write bundle for the writeback stage.
// The slave modport is the writeback stage's view; the master modport is the driver's view.
interface alu_writeback_stage_if #(
    parameter int unsigned REG_AW = 4
);
    localparam int unsigned DATA_W = 20;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_result_b;
    logic              in_dual;
    logic              in_we;
    logic [REG_AW-1:0] in_dst_a;
    logic [REG_AW-1:0] in_dst_b;
    logic [2:0]        in_flag_we;
    logic [2:0]        in_flags;
    logic [1:0]        in_sr_op;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;

    modport master (
        output in_valid, in_mode, in_result, in_result_b, in_dual, in_we,
               in_dst_a, in_dst_b, in_flag_we, in_flags, in_sr_op, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_mode, in_result, in_result_b, in_dual, in_we,
               in_dst_a, in_dst_b, in_flag_we, in_flags, in_sr_op, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: buffers ALU results in a small FIFO, drains them to the
// register-file write port (two writes for swap entries) and owns the status register.
// Optional macro WB_STALL_CNT_EN adds stall_cnt, a saturating count of stalled write cycles.
module alu_writeback_stage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned REG_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_writeback_stage_if.slave  bus,
    output logic                  sr_zero,
    output logic                  sr_sign,
    output logic                  sr_carry,
    output logic                  busy
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int unsigned DATA_W = 20;
    localparam int unsigned HALF_W = 10;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR_A = 2'd1;
    localparam logic [1:0] ST_WR_B = 2'd2;

    localparam logic [1:0] SR_OP_LOAD = 2'b01;
    localparam logic [1:0] SR_OP_XOR  = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] result_a;
        logic [DATA_W-1:0] result_b;
        logic              dual;
        logic              we;
        logic [REG_AW-1:0] dst_a;
        logic [REG_AW-1:0] dst_b;
        logic [2:0]        flag_we;
        logic [2:0]        flags;
        logic [1:0]        sr_op;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [2:0]        sr_q, sr_d;
    logic              busy_q, busy_d;

    logic              push_c;
    logic              retire_c;
    logic              go_b_c;
    logic              nxt_valid_c;
    logic [PTR_W-1:0]  rd_ptr_inc_c;
    entry_t            push_entry_c;
    entry_t            head_c;
    entry_t            nxt_c;

    // Next-state, FIFO bookkeeping, write-port and status-register update
    always_comb begin
        push_c       = bus.in_valid && in_ready_q;
        retire_c     = 1'b0;
        go_b_c       = 1'b0;
        nxt_valid_c  = 1'b0;
        rd_ptr_inc_c = rd_ptr_q + PTR_W'(1);
        head_c       = mem_q[rd_ptr_q];
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        sr_d         = sr_q;

        // Half-word entries are stored with the upper half cleared
        push_entry_c.result_a = bus.in_mode ? bus.in_result
                                            : DATA_W'(bus.in_result[HALF_W-1:0]);
        push_entry_c.result_b = bus.in_mode ? bus.in_result_b
                                            : DATA_W'(bus.in_result_b[HALF_W-1:0]);
        push_entry_c.dual     = bus.in_dual;
        push_entry_c.we       = bus.in_we;
        push_entry_c.dst_a    = bus.in_dst_a;
        push_entry_c.dst_b    = bus.in_dst_b;
        push_entry_c.flag_we  = bus.in_flag_we;
        push_entry_c.flags    = bus.in_flags;
        push_entry_c.sr_op    = bus.in_sr_op;

        case (state_q)
            ST_IDLE: retire_c = (count_q != '0) && !head_c.we;
            ST_WR_A: begin
                if (bus.rf_ready) begin
                    if (head_c.dual) go_b_c = 1'b1;
                    else             retire_c = 1'b1;
                end
            end
            ST_WR_B: retire_c = bus.rf_ready;
            default: ;
        endcase

        // Entry that will be at the head next cycle; an empty FIFO forwards the push
        if (retire_c) begin
            nxt_valid_c = (count_q >= CNT_W'(2)) || push_c;
            nxt_c       = (count_q >= CNT_W'(2)) ? mem_q[rd_ptr_inc_c] : push_entry_c;
        end else begin
            nxt_valid_c = (count_q != '0) || push_c;
            nxt_c       = (count_q != '0) ? head_c : push_entry_c;
        end

        if (go_b_c) begin
            state_d = ST_WR_B;
        end else if ((state_q == ST_IDLE) || retire_c) begin
            state_d = (nxt_valid_c && nxt_c.we) ? ST_WR_A : ST_IDLE;
        end

        // Write port loads only when a new write starts; otherwise held
        if (go_b_c) begin
            rf_waddr_d = head_c.dst_b;
            rf_wdata_d = head_c.result_b;
        end else if ((state_d == ST_WR_A) && ((state_q == ST_IDLE) || retire_c)) begin
            rf_waddr_d = nxt_c.dst_a;
            rf_wdata_d = nxt_c.result_a;
        end
        rf_we_d = (state_d != ST_IDLE);

        if (push_c) begin
            mem_d[wr_ptr_q] = push_entry_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (retire_c) begin
            rd_ptr_d = rd_ptr_inc_c;
        end
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(retire_c);
        in_ready_d = (count_d != CNT_W'(DEPTH));
        busy_d     = (count_d != '0) || (state_d != ST_IDLE);

        // Status register is updated by the retiring entry
        if (retire_c) begin
            case (head_c.sr_op)
                SR_OP_LOAD: sr_d = head_c.result_a[2:0];
                SR_OP_XOR:  sr_d = sr_q ^ head_c.result_a[2:0];
                default:    sr_d = (sr_q & ~head_c.flag_we) | (head_c.flags & head_c.flag_we);
            endcase
        end
    end

    // State, FIFO and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sr_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sr_q       <= sr_d;
            busy_q     <= busy_d;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a write is offered but not accepted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rf_we_q && !bus.rf_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign sr_zero      = sr_q[0];
    assign sr_sign      = sr_q[1];
    assign sr_carry     = sr_q[2];
    assign busy         = busy_q;

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Downstream stage of the 20-bit ALU. It buffers ALU results and their zero/sign/carry flags in a small FIFO and drains them into the register-file write port under a valid/ready handshake. It also owns the architectural status register and implements the load-status and XOR-status operations. Swap results are written as two register writes on consecutive accepted cycles.

Parameters:
DEPTH, 2, input FIFO entries (power of two, 2..8)
REG_AW, 4, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid
in_ready  out  1  stage can accept an entry (FIFO not full)
in_mode  in  1  1 = full word (20 bits), 0 = half word (10 bits)
in_result  in  20  primary result
in_result_b  in  20  second result, used only when in_dual=1 (swap)
in_dual  in  1  entry writes two registers
in_we  in  1  entry writes the register file
in_dst_a  in  REG_AW  destination for in_result
in_dst_b  in  REG_AW  destination for in_result_b
in_flag_we  in  3  per-flag update mask {carry,sign,zero}
in_flags  in  3  ALU flags {carry,sign,zero}
in_sr_op  in  2  00 none, 01 load SR, 10 XOR SR, 11 reserved (treated as none)
rf_we  out  1  write request
rf_waddr  out  REG_AW  write address
rf_wdata  out  20  write data
rf_ready  in  1  register file accepts the write this cycle
sr_zero, sr_sign, sr_carry  out  1 each  architectural status flags
busy  out  1  FIFO non-empty or a write is in flight

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, FSM in IDLE. All outputs are 0 except in_ready, which is 1.
- Push: occurs when in_valid && in_ready. in_ready = !full, registered. There is no pop-through into a full FIFO: an entry freed in a cycle makes in_ready rise the following cycle.
- Half-word masking is applied at push: in_result[19:10] and in_result_b[19:10] are stored as 0 when in_mode=0.
- FSM: IDLE -> WR_A when the FIFO is non-empty and head in_we=1. WR_A -> WR_B on rf_ready if dual, else it retires. WR_B -> retire on rf_ready. Head with in_we=0 retires directly from IDLE in one cycle.
- Retire: head is popped. The FSM returns to IDLE, or goes straight to WR_A if the next entry is present (back-to-back, one write per cycle).
- rf_we=1 in WR_A/WR_B only. waddr/wdata are dst_a/result in WR_A and dst_b/result_b in WR_B. All three are held stable until rf_ready.
- Latency: push in cycle N -> rf_we earliest in cycle N+1.
- Status update occurs at retire and is visible the next cycle:
  - sr_op=01: SR <= result[2:0] as {carry,sign,zero}.
  - sr_op=10: SR <= SR ^ result[2:0].
  - Otherwise each flag bit i is loaded from in_flags[i] where in_flag_we[i]=1.
  - When sr_op is 01 or 10, in_flag_we is ignored.
- Dual entry where dst_a==dst_b: both writes are issued; the last write (result_b) wins.
- Reset mid-write: the write is abandoned, rf_we drops immediately, and SR is cleared.
- busy = !empty || state!=IDLE.

Optional Feature:
WB_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0], which counts cycles with rf_we && !rf_ready. The counter saturates at 16'hFFFF and resets to 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Full-word single write: push result=20'hABCDE, dst_a=3, we=1, flag_we=3'b111, flags=3'b010, rf_ready=1. Expect rf_we with waddr=3, wdata=ABCDE one cycle after push. SR sign=1, zero=0, carry=0 the cycle after that.
- Half-word masking and swap: push mode=0, dual=1, result=20'hFFFFF->dst 1, result_b=20'h12345->dst 2. Expect writes 003FF@1 then 00345@2 on consecutive cycles.
- Backpressure and full: hold rf_ready=0 and push 3 entries with DEPTH=2. Expect in_ready=0 after the 2nd push and wdata held stable. Release rf_ready: entries drain in order, and in_ready returns the cycle after the first retire.
- SR ops: load SR from result=20'h00005 -> {c,s,z}=101. Then XOR with 20'h00003 -> 110. Flag_we on those entries has no effect.
- Non-writing entry: we=0, flag_we=3'b001, flags zero=1. Expect no rf_we, sr_zero=1 two cycles after push, and busy deasserting.
- Async reset during WR_B stall: assert rst_n=0 mid-cycle. Expect rf_we=0, SR=0, in_ready=1 immediately. With WB_STALL_CNT_EN defined, stall_cnt=0 after reset.
